// File: rtl/cache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : cache_dm
//  Purpose  : Direct-mapped, write-through, no-write-allocate cache, one
//             32-bit word per line, sitting between a CPU and a slow RAM.
//  Revision : 1.0  initial release
// ============================================================================
module cache_dm #(
  parameter int INDEX_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_RD_MEM = 2'd1;
  localparam logic [1:0] c_WR_MEM = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]         r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag_mem  [LINES];
  logic [31:0]        r_data_mem [LINES];
  logic [29:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [15:0]        r_hit_count;
  logic [15:0]        r_miss_count;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_rindex;
  logic [TAG_W-1:0]   w_rtag;
  logic               w_hit;
  logic               w_fill;
  logic               w_wr_hit;
  logic               w_unused_addr;

  assign w_index       = addr[INDEX_W+1:2];
  assign w_tag         = addr[31:INDEX_W+2];
  assign w_rindex      = r_addr[INDEX_W-1:0];
  assign w_rtag        = r_addr[29:INDEX_W];
  assign w_unused_addr = ^addr[1:0];

  assign w_hit    = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
  assign w_fill   = (r_state == c_RD_MEM) && mem_ready;
  assign w_wr_hit = (r_state == c_IDLE) && write && !read && w_hit;

  assign rdata      = r_rdata;
  assign ready      = (r_state == c_DONE);
  assign mem_read   = (r_state == c_RD_MEM);
  assign mem_write  = (r_state == c_WR_MEM);
  assign mem_addr   = {r_addr, 2'b00};
  assign mem_wdata  = r_wdata;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Control, valid bits and counters; the asynchronous reset aborts any RAM
  // transaction because the RAM strobes decode straight from the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_valid      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (read) begin
            if (w_hit) begin
              r_rdata     <= r_data_mem[w_index];
              r_hit_count <= r_hit_count + 16'd1;
              r_state     <= c_DONE;
            end else begin
              r_addr       <= addr[31:2];
              r_miss_count <= r_miss_count + 16'd1;
              r_state      <= c_RD_MEM;
            end
          end else if (write) begin
            r_addr  <= addr[31:2];
            r_wdata <= wdata;
            r_state <= c_WR_MEM;
          end
        end
        c_RD_MEM: begin
          if (mem_ready) begin
            r_rdata           <= mem_rdata;
            r_valid[w_rindex] <= 1'b1;
            r_state           <= c_DONE;
          end
        end
        c_WR_MEM: begin
          if (mem_ready) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Line storage is not reset; the valid bits alone qualify its contents.
  always_ff @(posedge clock) begin
    if (w_wr_hit) begin
      r_data_mem[w_index] <= wdata;
    end
    if (w_fill) begin
      r_data_mem[w_rindex] <= mem_rdata;
      r_tag_mem[w_rindex]  <= w_rtag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_dm.sv
`default_nettype none
// Directed testbench for cache_dm: linear transaction sequence, a bench-side
// RAM responder with programmable latency and immediate-assertion checks.
module tb_cache_dm;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int          tests;
  int          fails;

  int          n_cyc;
  int          n_rd;
  int          n_wr;
  int          n_both;
  logic [31:0] got;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;

  cache_dm #(.INDEX_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; the RAM answers on the lat-th cycle of its request.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input int lat, input logic [31:0] rdat);
    int   k;
    int   mc;
    logic done;
    @(negedge clock);
    read   = rd;
    write  = wr;
    addr   = a;
    wdata  = wd;
    n_rd   = 0;
    n_wr   = 0;
    n_both = 0;
    mc     = 0;
    k      = 0;
    done   = 1'b0;
    seen_addr  = 32'hx;
    seen_wdata = 32'hx;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (mem_read && mem_write) n_both++;
      if (mem_read || mem_write) begin
        mc++;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end
      if (ready) begin
        done      = 1'b1;
        got       = rdata;
        read      = 1'b0;
        write     = 1'b0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = (mem_read || mem_write) && (mc >= lat);
        mem_rdata = rdat;
      end
      if (k == 1) begin
        addr  = ~a;
        wdata = ~wd;
      end
    end
    n_cyc = k;
    chk("no_timeout", 32'(done), 32'd1);
    chk("never_rd_and_wr", 32'(n_both), 32'd0);
  endtask

  // ready must be a single-cycle pulse and rdata must hold afterwards.
  task automatic post_chk(input string tag);
    @(negedge clock);
    chk({tag, "_ready_drop"}, 32'(ready), 32'd0);
    chk({tag, "_rdata_hold"}, rdata, got);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    got       = 32'h0;

    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_hit", 32'(hit_count), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Cold read miss, RAM answers after 3 cycles
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEADBEEF);
    chk("miss1_mem_read_cycles", 32'(n_rd), 32'd3);
    chk("miss1_latency", 32'(n_cyc), 32'd4);
    chk("miss1_mem_addr", seen_addr, 32'h0000_0040);
    chk("miss1_rdata", got, 32'hDEADBEEF);
    chk("miss1_miss_count", 32'(miss_count), 32'd1);
    chk("miss1_hit_count", 32'(hit_count), 32'd0);
    post_chk("miss1");

    // Repeat read hits with single-cycle latency
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
    chk("hit1_latency", 32'(n_cyc), 32'd1);
    chk("hit1_no_mem_read", 32'(n_rd), 32'd0);
    chk("hit1_rdata", got, 32'hDEADBEEF);
    chk("hit1_hit_count", 32'(hit_count), 32'd1);
    post_chk("hit1");

    // Write hit goes through to RAM and updates the line
    xact(1'b0, 1'b1, 32'h0000_0040, 32'h12345678, 2, 32'h0);
    chk("wr1_mem_write_cycles", 32'(n_wr), 32'd2);
    chk("wr1_no_mem_read", 32'(n_rd), 32'd0);
    chk("wr1_latency", 32'(n_cyc), 32'd3);
    chk("wr1_mem_addr", seen_addr, 32'h0000_0040);
    chk("wr1_mem_wdata", seen_wdata, 32'h12345678);
    chk("wr1_counters", {hit_count, miss_count}, {16'd1, 16'd1});
    post_chk("wr1");
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
    chk("hit2_no_mem_read", 32'(n_rd), 32'd0);
    chk("hit2_rdata", got, 32'h12345678);
    chk("hit2_hit_count", 32'(hit_count), 32'd2);

    // Conflict on index 0 replaces the line
    xact(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1, 32'hCAFEF00D);
    chk("conf_miss_mem_read", 32'(n_rd), 32'd1);
    chk("conf_rdata", got, 32'hCAFEF00D);
    chk("conf_miss_count", 32'(miss_count), 32'd2);
    xact(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1, 32'h0);
    chk("conf_hit_rdata", got, 32'hCAFEF00D);
    chk("conf_hit_count", 32'(hit_count), 32'd3);
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h11111111);
    chk("evict_mem_read", 32'(n_rd), 32'd1);
    chk("evict_rdata", got, 32'h11111111);
    chk("evict_miss_count", 32'(miss_count), 32'd3);

    // Write miss to index 0 must leave the resident 0x40 line alone
    xact(1'b0, 1'b1, 32'h0000_0100, 32'hAAAA5555, 1, 32'h0);
    chk("wrmiss_mem_write", 32'(n_wr), 32'd1);
    chk("wrmiss_mem_wdata", seen_wdata, 32'hAAAA5555);
    chk("wrmiss_mem_addr", seen_addr, 32'h0000_0100);
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
    chk("wrmiss_keep_rdata", got, 32'h11111111);
    chk("wrmiss_keep_hit", 32'(hit_count), 32'd4);
    xact(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0BADF00D);
    chk("wrmiss_rd_mem_read", 32'(n_rd), 32'd1);
    chk("wrmiss_rd_rdata", got, 32'h0BADF00D);
    chk("wrmiss_rd_miss_count", 32'(miss_count), 32'd4);

    // Read and write together: only the read is serviced
    xact(1'b1, 1'b1, 32'h0000_0044, 32'h55555555, 2, 32'h00C0FFEE);
    chk("rdwr_no_mem_write", 32'(n_wr), 32'd0);
    chk("rdwr_mem_read", 32'(n_rd), 32'd2);
    chk("rdwr_rdata", got, 32'h00C0FFEE);
    chk("rdwr_miss_count", 32'(miss_count), 32'd5);

    // Byte offset bits are ignored for lookup
    xact(1'b1, 1'b0, 32'h0000_0047, 32'h0, 1, 32'h0);
    chk("offs_hit_latency", 32'(n_cyc), 32'd1);
    chk("offs_hit_rdata", got, 32'h00C0FFEE);
    chk("offs_hit_count", 32'(hit_count), 32'd5);

    // Asynchronous reset in the middle of a RAM read
    @(negedge clock);
    read = 1'b1;
    addr = 32'h0000_0200;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_mem_read_before", 32'(mem_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_mem_read_drop", 32'(mem_read), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_counters", {hit_count, miss_count}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_ready", 32'(ready), 32'd0);
    read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    xact(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h76543210);
    chk("postrst_mem_read", 32'(n_rd), 32'd1);
    chk("postrst_rdata", got, 32'h76543210);
    chk("postrst_miss_count", 32'(miss_count), 32'd1);
    xact(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h99990000);
    chk("postrst_valid_cleared", 32'(n_rd), 32'd1);
    chk("postrst_miss_count2", 32'(miss_count), 32'd2);
    chk("postrst_hit_count", 32'(hit_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
